eye_core_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle `cpu` top. It fetches 32-bit instructions over a request/valid handshake, so instruction memory may insert wait states. It executes through a FETCH/WAIT/EXEC/HALT state machine and writes back to an internal register file with width and depth set by parameters. It sits between the program ROM and the rest of the system. A debug writeback port exposes every register write to the bench.

---
 rtl/eye_core_mc.sv | 198 +++++++++++++++++++
 tb/tb_eye_core_mc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eye_core_mc.sv
// eye_core_mc: multi-cycle core with a FETCH/WAIT/EXEC/HALT sequencer, handshake
// instruction fetch and a parametrised register file. Defining EYE_CARRY_EN adds a
// carry flag, carry updates on ADD/ADDI/SUB, and the ADC/SBC opcodes.
module eye_core_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_N  = 32,
    parameter int unsigned PC_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_rdata,
    output logic [PC_W-1:0]          pc_out,
    output logic                     halted,
    output logic                     illegal,
    output logic                     dbg_we,
    output logic [$clog2(REG_N)-1:0] dbg_waddr,
    output logic [DATA_W-1:0]        dbg_wdata
);
    localparam int unsigned AW = $clog2(REG_N);

    localparam logic [5:0] OpNop  = 6'd0;
    localparam logic [5:0] OpAdd  = 6'd1;
    localparam logic [5:0] OpSub  = 6'd2;
    localparam logic [5:0] OpAnd  = 6'd3;
    localparam logic [5:0] OpOr   = 6'd4;
    localparam logic [5:0] OpXor  = 6'd5;
    localparam logic [5:0] OpAddi = 6'd6;
    localparam logic [5:0] OpLdi  = 6'd7;
    localparam logic [5:0] OpJmp  = 6'd8;
    localparam logic [5:0] OpBnz  = 6'd9;
`ifdef EYE_CARRY_EN
    localparam logic [5:0] OpAdc  = 6'd10;
    localparam logic [5:0] OpSbc  = 6'd11;
`endif
    localparam logic [5:0] OpHlt  = 6'd63;

    typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [REG_N];

    logic [5:0]        opcode;
    logic [AW-1:0]     rd, rs1, rs2;
    logic [31:0]       imm_ext;
    logic [DATA_W-1:0] imm, op_a, op_b, wr_val;
    logic [DATA_W:0]   add_full, sub_full, addi_full;
    logic              wr_en, illegal_c;

    assign opcode  = ir_q[5:0];
    assign rd      = ir_q[6 +: AW];
    assign rs1     = ir_q[11 +: AW];
    assign rs2     = ir_q[16 +: AW];
    assign imm_ext = {16'b0, ir_q[31:16]};
    assign imm     = imm_ext[DATA_W-1:0];

    // r0 is hardwired to zero on the read side as well.
    assign op_a = (rs1 == '0) ? '0 : regs_q[rs1];
    assign op_b = (rs2 == '0) ? '0 : regs_q[rs2];

    // One extra bit on each sum keeps the carry / borrow out.
    assign add_full  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
    assign addi_full = {1'b0, op_a} + {1'b0, imm};

`ifdef EYE_CARRY_EN
    logic            carry_q, carry_d;
    logic [DATA_W:0] adc_full, sbc_full;
    assign adc_full = add_full + {{DATA_W{1'b0}}, carry_q};
    assign sbc_full = sub_full - {{DATA_W{1'b0}}, ~carry_q};
    logic unused_bits;
    assign unused_bits = ^{ir_q, imm_ext};
`else
    logic unused_bits;
    assign unused_bits = ^{ir_q, imm_ext, add_full[DATA_W], sub_full[DATA_W],
                           addi_full[DATA_W]};
`endif

    // Sequencer next state, execute datapath and PC update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
`ifdef EYE_CARRY_EN
        carry_d   = carry_q;
`endif
        wr_en     = 1'b0;
        wr_val    = '0;
        illegal_c = 1'b0;
        case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_q + PC_W'(1);
                case (opcode)
                    OpNop: begin end
                    OpAdd: begin
                        wr_en  = 1'b1;
                        wr_val = add_full[DATA_W-1:0];
`ifdef EYE_CARRY_EN
                        carry_d = add_full[DATA_W];
`endif
                    end
                    OpSub: begin
                        wr_en  = 1'b1;
                        wr_val = sub_full[DATA_W-1:0];
`ifdef EYE_CARRY_EN
                        carry_d = ~sub_full[DATA_W];
`endif
                    end
                    OpAnd: begin wr_en = 1'b1; wr_val = op_a & op_b; end
                    OpOr:  begin wr_en = 1'b1; wr_val = op_a | op_b; end
                    OpXor: begin wr_en = 1'b1; wr_val = op_a ^ op_b; end
                    OpAddi: begin
                        wr_en  = 1'b1;
                        wr_val = addi_full[DATA_W-1:0];
`ifdef EYE_CARRY_EN
                        carry_d = addi_full[DATA_W];
`endif
                    end
                    OpLdi: begin wr_en = 1'b1; wr_val = imm; end
                    OpJmp: pc_d = ir_q[16 +: PC_W];
                    OpBnz: begin
                        if (op_a != '0) pc_d = ir_q[16 +: PC_W];
                    end
`ifdef EYE_CARRY_EN
                    OpAdc: begin
                        wr_en   = 1'b1;
                        wr_val  = adc_full[DATA_W-1:0];
                        carry_d = adc_full[DATA_W];
                    end
                    OpSbc: begin
                        wr_en   = 1'b1;
                        wr_val  = sbc_full[DATA_W-1:0];
                        carry_d = ~sbc_full[DATA_W];
                    end
`endif
                    // HALT keeps the PC on the HLT instruction.
                    OpHlt: begin
                        state_d = StHalt;
                        pc_d    = pc_q;
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Outputs stay quiet while reset is held, whatever the stale state says.
    assign imem_req  = rst_n && (state_q == StFetch);
    assign imem_addr = rst_n ? pc_q : '0;
    assign pc_out    = rst_n ? pc_q : '0;
    assign halted    = rst_n && (state_q == StHalt);
    assign illegal   = rst_n && illegal_c;
    assign dbg_we    = rst_n && wr_en && (rd != '0);
    assign dbg_waddr = dbg_we ? rd : '0;
    assign dbg_wdata = dbg_we ? wr_val : '0;

    // Sequencer, PC, IR and carry registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
`ifdef EYE_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef EYE_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    // Register file write port; dbg_we already excludes r0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else if (dbg_we) begin
            regs_q[rd] <= wr_val;
        end
    end
endmodule

// File: tb/tb_eye_core_mc.sv
// Testbench for eye_core_mc: directed programs, latency-configurable instruction
// memory, scoreboard of expected register writes, plus a small PC_W=4/DATA_W=8
// instance for wrap-around behaviour.
module tb_eye_core_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_valid, halted, illegal, dbg_we;
    logic [15:0] imem_addr, pc_out, dbg_wdata;
    logic [31:0] imem_rdata;
    logic [4:0]  dbg_waddr;

    logic        w_req, w_halted, w_illegal, w_we;
    logic        w_valid = 1'b0;
    logic        w_req_prev = 1'b0;
    logic [3:0]  w_addr, w_pc;
    logic [31:0] w_rdata = '0;
    logic [1:0]  w_waddr;
    logic [7:0]  w_wdata;

    logic [31:0] mem [64];
    logic [31:0] mem_w [16];
    logic        mem_en = 1'b1;
    int          lat = 1;
    int          cnt = 0;
    logic [15:0] addr_l = '0;
    int          fetch1 = 0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        man_valid = 1'b0;
    logic [31:0] man_data = '0;

    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          n_illegal = 0;

    always #5 clk = ~clk;

    assign imem_valid = resp_valid | man_valid;
    assign imem_rdata = man_valid ? man_data : resp_data;

    eye_core_mc u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .pc_out    (pc_out),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_we    (dbg_we),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata)
    );

    eye_core_mc #(.DATA_W(8), .REG_N(4), .PC_W(4)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (w_req),
        .imem_addr (w_addr),
        .imem_valid(w_valid),
        .imem_rdata(w_rdata),
        .pc_out    (w_pc),
        .halted    (w_halted),
        .illegal   (w_illegal),
        .dbg_we    (w_we),
        .dbg_waddr (w_waddr),
        .dbg_wdata (w_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        return {imm, rs1, rd, op};
    endfunction

    function automatic logic [63:0] pack(input logic [4:0] a, input logic [15:0] d);
        return {27'b0, a, 16'b0, d};
    endfunction

    // Main memory: valid arrives lat cycles after each request, address must hold.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (!rst_n || !mem_en) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                chk("addr_stable", 64'(imem_addr), 64'(addr_l));
                cnt--;
                if (cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = mem[addr_l[5:0]];
                end
            end
            if (imem_req) begin
                addr_l = imem_addr;
                cnt    = lat;
                if (imem_addr == 16'd1) fetch1++;
            end
        end
    end

    // Small instance memory: zero-wait, valid in the cycle after the request.
    always @(negedge clk) begin
        w_valid    = w_req_prev;
        w_rdata    = mem_w[w_addr];
        w_req_prev = w_req;
    end

    // Scoreboard: every debug write must match the next expected (addr, data).
    always @(negedge clk) begin
        logic [63:0] e;
        if (illegal) begin
            n_illegal++;
            chk("illegal_with_we", 64'(dbg_we), 64'(0));
        end
        if (dbg_we) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed r%0d=%0h expected none",
                       dbg_waddr, dbg_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb", pack(dbg_waddr, dbg_wdata), e);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        man_valid = 1'b0;
        n_illegal = 0;
        fetch1    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_illegal", 64'(illegal), 64'(0));
        chk("rst_we", 64'(dbg_we), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(0));
        chk("rst_pc", 64'(pc_out), 64'(0));
        chk("rst_waddr", 64'(dbg_waddr), 64'(0));
        chk("rst_wdata", 64'(dbg_wdata), 64'(0));
        rst_n = 1'b1;
    endtask

    // Returns the 1-based cycle after reset release where halted is first seen, 0 on timeout.
    task automatic run_until_halt(input int max_cyc, output int n_out);
        n_out = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (halted) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        int hc;
        for (int i = 0; i < 16; i++) mem_w[i] = '0;
        mem_w[0] = enc(6'd7, 5'd1, 5'd0, 16'h00FF);
        mem_w[1] = enc(6'd6, 5'd1, 5'd1, 16'h0001);

        // Zero-wait basic program, with the wrap instance running alongside.
        clear_mem();
        mem[0] = enc(6'd7, 5'd1, 5'd0, 16'd5);
        mem[1] = enc(6'd6, 5'd2, 5'd1, 16'd3);
        mem[2] = enc(6'd1, 5'd3, 5'd1, 16'd2);
        mem[3] = enc(6'd63, 5'd0, 5'd0, 16'd0);
        exp_q.push_back(pack(5'd1, 16'd5));
        exp_q.push_back(pack(5'd2, 16'd8));
        exp_q.push_back(pack(5'd3, 16'd13));
        lat = 1;
        do_reset();
        for (int n = 1; n <= 51; n++) begin
            @(negedge clk);
            if (n == 1) chk("first_req", 64'(imem_req), 64'(1));
            if (n == 12) chk("halt_early", 64'(halted), 64'(0));
            if (n >= 13) begin
                chk("halted", 64'(halted), 64'(1));
                chk("req_after_halt", 64'(imem_req), 64'(0));
            end
            if (n == 3) chk("w_ldi", {w_we, w_waddr, w_wdata, w_illegal, w_halted},
                            {1'b1, 2'd1, 8'hFF, 1'b0, 1'b0});
            if (n == 6) chk("w_addi_wrap", {w_we, w_wdata}, {1'b1, 8'h00});
            if (n == 48) chk("w_pc15", 64'(w_pc), 64'(15));
            if (n == 49) chk("w_pc_wrap", {w_req, w_addr, w_pc}, {1'b1, 4'd0, 4'd0});
            if (n == 51) chk("w_ldi_again", {w_we, w_wdata, w_halted}, {1'b1, 8'hFF, 1'b0});
        end
        chk("a_pc", 64'(pc_out), 64'(3));
        chk("a_drain", 64'(exp_q.size()), 64'(0));

        // Same program with four-cycle memory latency: 6 cycles per instruction.
        exp_q.push_back(pack(5'd1, 16'd5));
        exp_q.push_back(pack(5'd2, 16'd8));
        exp_q.push_back(pack(5'd3, 16'd13));
        lat = 4;
        do_reset();
        run_until_halt(100, hc);
        chk("ws_halt_cycle", 64'(hc), 64'(25));
        chk("ws_pc", 64'(pc_out), 64'(3));
        chk("ws_drain", 64'(exp_q.size()), 64'(0));

        // Countdown loop: BNZ taken twice, then falls through to HLT.
        clear_mem();
        mem[0] = enc(6'd7, 5'd1, 5'd0, 16'd3);
        mem[1] = enc(6'd6, 5'd1, 5'd1, 16'hFFFF);
        mem[2] = enc(6'd9, 5'd0, 5'd1, 16'd1);
        mem[3] = enc(6'd63, 5'd0, 5'd0, 16'd0);
        for (int v = 3; v >= 0; v--) exp_q.push_back(pack(5'd1, 16'(v)));
        lat = 1;
        do_reset();
        run_until_halt(100, hc);
        chk("loop_halt_cycle", 64'(hc), 64'(25));
        chk("loop_fetch1", 64'(fetch1), 64'(3));
        chk("loop_pc", 64'(pc_out), 64'(3));
        chk("loop_drain", 64'(exp_q.size()), 64'(0));

        // r0 writes discarded, r0 reads zero, undefined opcodes pulse illegal.
        clear_mem();
        mem[0] = enc(6'd7, 5'd0, 5'd0, 16'd7);
        mem[1] = enc(6'd1, 5'd4, 5'd0, 16'd0);
        mem[2] = 32'h0000_002A;
        mem[3] = enc(6'd7, 5'd7, 5'd0, 16'd9);
        mem[4] = enc(6'd10, 5'd8, 5'd0, 16'd0);
        mem[5] = enc(6'd63, 5'd0, 5'd0, 16'd0);
        exp_q.push_back(pack(5'd4, 16'd0));
        exp_q.push_back(pack(5'd7, 16'd9));
`ifdef EYE_CARRY_EN
        exp_q.push_back(pack(5'd8, 16'd0));
`endif
        do_reset();
        run_until_halt(100, hc);
        chk("ill_halt_cycle", 64'(hc), 64'(19));
        chk("ill_pc", 64'(pc_out), 64'(5));
`ifdef EYE_CARRY_EN
        chk("ill_count", 64'(n_illegal), 64'(1));
`else
        chk("ill_count", 64'(n_illegal), 64'(2));
`endif
        chk("ill_drain", 64'(exp_q.size()), 64'(0));

`ifdef EYE_CARRY_EN
        // Carry out of ADDI feeds ADC.
        clear_mem();
        mem[0] = enc(6'd7, 5'd1, 5'd0, 16'hFFFF);
        mem[1] = enc(6'd6, 5'd2, 5'd1, 16'd1);
        mem[2] = enc(6'd10, 5'd3, 5'd0, 16'd0);
        mem[3] = enc(6'd63, 5'd0, 5'd0, 16'd0);
        exp_q.push_back(pack(5'd1, 16'hFFFF));
        exp_q.push_back(pack(5'd2, 16'h0000));
        exp_q.push_back(pack(5'd3, 16'h0001));
        do_reset();
        run_until_halt(100, hc);
        chk("carry_halt_cycle", 64'(hc), 64'(13));
        chk("carry_drain", 64'(exp_q.size()), 64'(0));
`endif

        // Reset during WAIT; a late valid in the first FETCH after release is ignored.
        mem_en = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rw_req", {imem_req, imem_addr}, {1'b1, 16'd0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_held", {imem_req, dbg_we, pc_out}, {1'b0, 1'b0, 16'd0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        man_valid = 1'b1;
        man_data  = enc(6'd7, 5'd5, 5'd0, 16'h0055);
        @(negedge clk);
        chk("rw_refetch", {imem_req, imem_addr, dbg_we}, {1'b1, 16'd0, 1'b0});
        exp_q.push_back(pack(5'd6, 16'h0066));
        @(posedge clk); #1;
        man_data = enc(6'd7, 5'd6, 5'd0, 16'h0066);
        @(posedge clk); #1;
        man_valid = 1'b0;
        @(negedge clk);
        chk("rw_exec_we", 64'(dbg_we), 64'(1));
        @(posedge clk); #1;
        chk("rw_pc", 64'(pc_out), 64'(1));
        chk("rw_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
